// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: state encoding, header byte offsets
// and the layout of one queued SDRAM write.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam int HB_MAP_MODE = 21;
  localparam int HB_ROM_TYPE = 22;
  localparam int HB_ROM_SIZE = 23;
  localparam int HB_RAM_SIZE = 24;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO holding pending SDRAM writes; head is shown
// combinationally so the arbiter sees it the cycle it becomes valid.
module word_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   r_wr;
  logic [PTR_W:0]   r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PTR_W] != r_rd[PTR_W]) &&
                   (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rd[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_clr) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + {{PTR_W{1'b0}}, 1'b1};
      if (w_pop)  r_rd <= r_rd + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr[PTR_W-1:0]] <= i_din;
  end

endmodule

// File: rtl/rom_loader.sv
// Streams a ROM image into SDRAM: captures a fixed-size header, pairs payload
// bytes into little-endian words and queues them as writes to the arbiter.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int          HDR_BYTES  = 64,
  parameter logic [22:0] ADDR_BASE  = 23'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic [7:0]  map_mode,
  output logic [7:0]  rom_type,
  output logic [7:0]  rom_size,
  output logic [7:0]  ram_size,
  output logic        header_valid,
  output logic [22:0] payload_bytes,
  output logic        overflow,
  output logic        load_done
);
  localparam logic [15:0] HDR_LAST = 16'(HDR_BYTES - 1);

  state_t      r_state, w_next;
  logic        r_load_d;
  logic [15:0] r_hcnt;
  logic [7:0]  r_lo;
  logic        r_have_lo;
  logic [22:0] r_addr;
  logic [22:0] r_pbytes;
  logic        r_ovf;
  logic        r_hv;
  logic [7:0]  r_map, r_type, r_rsize, r_ramsize;

  logic        w_rise, w_fall;
  logic        w_hdr_acc, w_pay_acc, w_flush_push, w_load_done;
  logic        w_word_done, w_drop;
  logic [15:0] w_word;
  wr_entry_t   w_push_ent, w_head;
  logic        w_empty, w_full;

  assign w_rise = rom_loading && !r_load_d;
  assign w_fall = !rom_loading && r_load_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_load_d <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_load_d <= rom_loading;
    end
  end

  // A new session edge wins over everything, including an unfinished drain.
  always_comb begin
    w_next = r_state;
    if (w_rise) begin
      w_next = (HDR_BYTES == 0) ? ST_DATA : ST_HEADER;
    end else begin
      case (r_state)
        ST_HEADER: if (w_fall) w_next = ST_IDLE;
                   else if (rom_do_valid && r_hcnt == HDR_LAST) w_next = ST_DATA;
        ST_DATA:   if (w_fall) w_next = ST_FLUSH;
        ST_FLUSH:  w_next = ST_DRAIN;
        ST_DRAIN:  if (w_empty) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_hdr_acc    = 1'b0;
    w_pay_acc    = 1'b0;
    w_flush_push = 1'b0;
    w_load_done  = 1'b0;
    if (!w_rise) begin
      case (r_state)
        ST_HEADER: w_hdr_acc    = rom_do_valid && !w_fall;
        ST_DATA:   w_pay_acc    = rom_do_valid && !w_fall;
        ST_FLUSH:  w_flush_push = r_have_lo;
        ST_DRAIN:  w_load_done  = w_empty;
        default:   ;
      endcase
    end
  end

  assign w_word_done = (w_pay_acc && r_have_lo) || w_flush_push;
  assign w_word      = w_flush_push ? {8'h00, r_lo} : {rom_do, r_lo};
  // Only a full FIFO that is not also popping this edge loses the word.
  assign w_drop      = w_word_done && w_full && !mem_ack;
  assign w_push_ent  = '{addr: r_addr, data: w_word};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt    <= '0;
      r_lo      <= '0;
      r_have_lo <= 1'b0;
      r_addr    <= {ADDR_BASE[22:1], 1'b0};
      r_pbytes  <= '0;
      r_ovf     <= 1'b0;
      r_hv      <= 1'b0;
      r_map     <= '0;
      r_type    <= '0;
      r_rsize   <= '0;
      r_ramsize <= '0;
    end else if (w_rise) begin
      r_hcnt    <= '0;
      r_have_lo <= 1'b0;
      r_addr    <= {ADDR_BASE[22:1], 1'b0};
      r_pbytes  <= '0;
      r_ovf     <= 1'b0;
      r_hv      <= (HDR_BYTES == 0);
      r_map     <= '0;
      r_type    <= '0;
      r_rsize   <= '0;
      r_ramsize <= '0;
    end else begin
      if (w_hdr_acc) begin
        r_hcnt <= r_hcnt + 16'd1;
        if (r_hcnt == 16'(HB_MAP_MODE)) r_map     <= rom_do;
        if (r_hcnt == 16'(HB_ROM_TYPE)) r_type    <= rom_do;
        if (r_hcnt == 16'(HB_ROM_SIZE)) r_rsize   <= rom_do;
        if (r_hcnt == 16'(HB_RAM_SIZE)) r_ramsize <= rom_do;
        if (r_hcnt == HDR_LAST)         r_hv      <= 1'b1;
      end
      if (w_pay_acc) begin
        r_pbytes  <= r_pbytes + 23'd1;
        r_have_lo <= !r_have_lo;
        if (!r_have_lo) r_lo <= rom_do;
      end
      if (w_flush_push) r_have_lo <= 1'b0;
      if (w_word_done) begin
        r_addr <= r_addr + 23'd2;
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  word_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_rise),
    .i_push (w_word_done && !w_drop),
    .i_din  (w_push_ent),
    .i_pop  (mem_ack),
    .o_dout (w_head),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  // Stale storage behind an empty FIFO is masked so idle outputs read zero.
  assign mem_req       = !w_empty;
  assign mem_addr      = mem_req ? w_head.addr : '0;
  assign mem_wdata     = mem_req ? w_head.data : '0;
  assign map_mode      = r_map;
  assign rom_type      = r_type;
  assign rom_size      = r_rsize;
  assign ram_size      = r_ramsize;
  assign header_valid  = r_hv;
  assign payload_bytes = r_pbytes;
  assign overflow      = r_ovf;
  assign load_done     = w_load_done;

endmodule
